// File: rtl/jinv_vector_checker.sv
// jinv_vector_checker: drives one stimulus word into an inverter bank,
// waits SETTLE_CYC clocks, checks y == ~a per bit and returns a result record.
//
// Parameters:
//   W          - stimulus/response width (number of inverters in the bank)
//   SETTLE_CYC - clocks between driving drv_a and sampling dut_y (1..255)
//   CNT_W      - width of pass/fail counters and the vector index
//
// Ports:
//   clk, rst_n           - rising-edge clock, synchronous active-low reset
//   stim_valid/ready/a   - stimulus handshake (ready only in IDLE)
//   drv_a                - registered drive to the DUT input
//   dut_y                - DUT output
//   res_valid/ready      - result record handshake
//   res_pass/a/y/idx     - result record contents
//   clr_cnt              - synchronous clear of counters, index, sticky flag
//   pass_cnt, fail_cnt   - saturating pass/fail counts
//   any_fail             - sticky fail flag
//   first_fail_idx       - index of the first failing vector
//
// Build option: define JINV_STICKY_FAIL_EN to implement any_fail and
// first_fail_idx; otherwise both are tied to zero.

module jinv_vector_checker #(
   parameter int W          = 1,
   parameter int SETTLE_CYC = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stim_valid,
   output logic             stim_ready,
   input  logic [W-1:0]     stim_a,
   output logic [W-1:0]     drv_a,
   input  logic [W-1:0]     dut_y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_pass,
   output logic [W-1:0]     res_a,
   output logic [W-1:0]     res_y,
   output logic [CNT_W-1:0] res_idx,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             any_fail,
   output logic [CNT_W-1:0] first_fail_idx
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q;
   state_t           state_d;
   logic [7:0]       settle_q;
   logic [CNT_W-1:0] index_q;
   logic             accept;
   logic             do_check;
   logic             chk_ok;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (stim_valid) state_d = SETTLE;
         end
         SETTLE: begin
            if (settle_q == 8'd0) state_d = CHECK;
         end
         CHECK: begin
            state_d = REPORT;
         end
         REPORT: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      stim_ready = 1'b0;
      res_valid  = 1'b0;
      do_check   = 1'b0;
      unique case (state_q)
         IDLE:    stim_ready = 1'b1;
         SETTLE:  ;
         CHECK:   do_check   = 1'b1;
         REPORT:  res_valid  = 1'b1;
         default: ;
      endcase
   end

   assign accept = stim_valid & stim_ready;

   // An X/Z bit never satisfies the equality, so the default fail holds.
   always_comb begin
      chk_ok = 1'b0;
      if ((dut_y ^ drv_a) == {W{1'b1}}) chk_ok = 1'b1;
   end

   // Drive, settle timer and result record
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drv_a    <= '0;
         settle_q <= '0;
         res_pass <= 1'b0;
         res_a    <= '0;
         res_y    <= '0;
         res_idx  <= '0;
      end else begin
         if (accept) begin
            drv_a    <= stim_a;
            settle_q <= SETTLE_LOAD;
         end else if (state_q == SETTLE && settle_q != 8'd0) begin
            settle_q <= settle_q - 8'd1;
         end
         if (do_check) begin
            res_pass <= chk_ok;
            res_a    <= drv_a;
            res_y    <= dut_y;
            res_idx  <= index_q;
         end
      end
   end

   // Counters and index; a coincident clear wins over the check update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
         index_q  <= '0;
      end else if (clr_cnt) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
         index_q  <= '0;
      end else if (do_check) begin
         index_q <= index_q + 1'b1;
         if (chk_ok) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
         end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
         end
      end
   end

`ifdef JINV_STICKY_FAIL_EN
   logic             any_fail_q;
   logic [CNT_W-1:0] first_fail_q;

   // Only the first failure after a clear is recorded
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         any_fail_q   <= 1'b0;
         first_fail_q <= '0;
      end else if (clr_cnt) begin
         any_fail_q   <= 1'b0;
         first_fail_q <= '0;
      end else if (do_check && !chk_ok && !any_fail_q) begin
         any_fail_q   <= 1'b1;
         first_fail_q <= index_q;
      end
   end

   assign any_fail       = any_fail_q;
   assign first_fail_idx = first_fail_q;
`else
   assign any_fail       = 1'b0;
   assign first_fail_idx = '0;
`endif

endmodule

// File: tb/tb_jinv_vector_checker.sv
// tb_jinv_vector_checker: directed self-checking bench for
// jinv_vector_checker with an ideal (or stuck-at-1) inverter model.

module tb_jinv_vector_checker;

   localparam int W     = 1;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             stim_valid;
   logic             stim_ready;
   logic [W-1:0]     stim_a;
   logic [W-1:0]     drv_a;
   logic [W-1:0]     dut_y;
   logic             res_valid;
   logic             res_ready;
   logic             res_pass;
   logic [W-1:0]     res_a;
   logic [W-1:0]     res_y;
   logic [CNT_W-1:0] res_idx;
   logic             clr_cnt;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic             any_fail;
   logic [CNT_W-1:0] first_fail_idx;

   logic stuck;
   int   n_chk;
   int   n_err;

   jinv_vector_checker #(
      .W(W),
      .SETTLE_CYC(4),
      .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .stim_valid(stim_valid),
      .stim_ready(stim_ready),
      .stim_a(stim_a),
      .drv_a(drv_a),
      .dut_y(dut_y),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_pass(res_pass),
      .res_a(res_a),
      .res_y(res_y),
      .res_idx(res_idx),
      .clr_cnt(clr_cnt),
      .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt),
      .any_fail(any_fail),
      .first_fail_idx(first_fail_idx)
   );

   assign dut_y = stuck ? {W{1'b1}} : ~drv_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Send one vector and check its record; optionally stall REPORT for
   // hold cycles (with an ignored stim pulse) or pulse clr_cnt in CHECK.
   task automatic send_vec(input logic a, input logic exp_pass,
                           input int exp_idx, input int hold,
                           input bit clr_chk);
      int  n;
      bit  seen;
      logic [W-1:0] exp_y;
      n = 0;
      while (!stim_ready && n < 10) begin
         cyc();
         n++;
      end
      check("ready_wait", 32'(stim_ready), 32'd1);
      exp_y      = stuck ? {W{1'b1}} : ~a;
      stim_valid = 1'b1;
      stim_a     = a;
      cyc();
      stim_valid = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         cyc();
         n++;
         if (n == 4 && clr_chk) clr_cnt = 1'b1;
         if (n == 5) clr_cnt = 1'b0;
         if (res_valid) seen = 1'b1;
      end
      clr_cnt = 1'b0;
      check("res_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check("latency", 32'(n), 32'd5);
      check("res_pass", 32'(res_pass), 32'(exp_pass));
      check("res_idx", 32'(res_idx), 32'(exp_idx[CNT_W-1:0]));
      check("res_a", 32'(res_a), 32'(a));
      check("res_y", 32'(res_y), 32'(exp_y));
      if (hold > 0) begin
         res_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            if (i == hold / 2) begin
               stim_valid = 1'b1;
               stim_a     = ~a;
            end
            cyc();
            stim_valid = 1'b0;
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_ready", 32'(stim_ready), 32'd0);
            check("hold_a", 32'(res_a), 32'(a));
            check("hold_idx", 32'(res_idx), 32'(exp_idx[CNT_W-1:0]));
            check("hold_drv", 32'(drv_a), 32'(a));
         end
         res_ready = 1'b1;
      end
      cyc();
      check("res_drop", 32'(res_valid), 32'd0);
      check("back_idle", 32'(stim_ready), 32'd1);
   endtask

   initial begin
      int  nv;
      logic exp_af;
      n_chk      = 0;
      n_err      = 0;
      stuck      = 1'b0;
      rst_n      = 1'b0;
      stim_valid = 1'b1;
      stim_a     = 1'b1;
      res_ready  = 1'b1;
      clr_cnt    = 1'b0;
`ifdef JINV_STICKY_FAIL_EN
      exp_af = 1'b1;
`else
      exp_af = 1'b0;
`endif

      // 1. reset with stim_valid high
      repeat (3) cyc();
      check("rst_drv", 32'(drv_a), 32'd0);
      check("rst_rv", 32'(res_valid), 32'd0);
      check("rst_pc", 32'(pass_cnt), 32'd0);
      check("rst_fc", 32'(fail_cnt), 32'd0);
      check("rst_idx", 32'(res_idx), 32'd0);
      check("rst_af", 32'(any_fail), 32'd0);
      rst_n      = 1'b1;
      stim_valid = 1'b0;
      check("rel_ready", 32'(stim_ready), 32'd1);

      // 2. ideal inverter, a = 1,0,1,0
      send_vec(1'b1, 1'b1, 0, 0, 1'b0);
      send_vec(1'b0, 1'b1, 1, 0, 1'b0);
      send_vec(1'b1, 1'b1, 2, 0, 1'b0);
      send_vec(1'b0, 1'b1, 3, 0, 1'b0);
      check("t2_pc", 32'(pass_cnt), 32'd4);
      check("t2_fc", 32'(fail_cnt), 32'd0);

      // 3. stuck-at-1 after a clear
      clr_cnt = 1'b1;
      cyc();
      clr_cnt = 1'b0;
      check("clr_pc", 32'(pass_cnt), 32'd0);
      stuck = 1'b1;
      send_vec(1'b1, 1'b0, 0, 0, 1'b0);
      send_vec(1'b0, 1'b1, 1, 0, 1'b0);
      check("t3_fc", 32'(fail_cnt), 32'd1);
      check("t3_pc", 32'(pass_cnt), 32'd1);
      check("t3_af", 32'(any_fail), 32'(exp_af));
      check("t3_ffi", 32'(first_fail_idx), 32'd0);
      send_vec(1'b1, 1'b0, 2, 0, 1'b0);
      check("t3_ffi2", 32'(first_fail_idx), 32'd0);
      check("t3_fc2", 32'(fail_cnt), 32'd2);
      stuck = 1'b0;

      // 4. consumer stall for 10 cycles
      send_vec(1'b1, 1'b1, 3, 10, 1'b0);
      check("t4_pc", 32'(pass_cnt), 32'd2);
      check("t4_drv", 32'(drv_a), 32'd1);

      // 5. clear in the CHECK cycle of a failing vector
      stuck = 1'b1;
      send_vec(1'b1, 1'b0, 4, 0, 1'b1);
      stuck = 1'b0;
      check("t5_fc", 32'(fail_cnt), 32'd0);
      check("t5_pc", 32'(pass_cnt), 32'd0);
      check("t5_af", 32'(any_fail), 32'd0);
      send_vec(1'b0, 1'b1, 0, 0, 1'b0);
      check("t5_pc2", 32'(pass_cnt), 32'd1);

      // 6a. reset during SETTLE
      stim_valid = 1'b1;
      stim_a     = 1'b1;
      cyc();
      stim_valid = 1'b0;
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         if (res_valid) nv++;
         cyc();
      end
      check("t6_norv", 32'(nv), 32'd0);
      check("t6_pc", 32'(pass_cnt), 32'd0);
      check("t6_idle", 32'(stim_ready), 32'd1);

      // 6b. saturation and index wrap
      for (int i = 0; i < 300; i++) begin
         send_vec(1'(i), 1'b1, i % 256, 0, 1'b0);
      end
      check("sat_pc", 32'(pass_cnt), 32'd255);
      check("sat_fc", 32'(fail_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
